// File: rtl/ll_desc_fetch_mc_if.sv
// DMA read-port bundle for the linked-list descriptor fetch engine.
// Master side issues the read and takes beats; slave side is the DMA.
interface ll_desc_fetch_mc_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          dma_r_req;
    logic [AW-1:0] dma_r_addr;
    logic [15:0]   dma_r_len;
    logic          dma_ack;
    logic          dma_vald;
    logic [DW-1:0] dma_data;
    logic          dma_dack;

    modport master (
        output dma_r_req, dma_r_addr, dma_r_len, dma_dack,
        input  dma_ack, dma_vald, dma_data
    );

    modport slave (
        input  dma_r_req, dma_r_addr, dma_r_len, dma_dack,
        output dma_ack, dma_vald, dma_data
    );
endinterface

// File: rtl/ll_desc_fetch_mc.sv
// Multi-channel linked-list descriptor fetch engine: round-robin grant,
// one fixed-length DMA read per grant, beats steered to the granted channel.
module ll_desc_fetch_mc #(
    parameter int NCH        = 4,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DESC_WORDS = 6,
    parameter int TMO        = 255
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [NCH-1:0]                    ll_req,
    input  logic [NCH*AW-1:0]                 ll_addr,
    output logic [NCH-1:0]                    ll_ack,
    output logic [NCH-1:0]                    ll_dvld,
    output logic [DW-1:0]                     ll_rdata,
    output logic [$clog2(DESC_WORDS+1)-1:0]   ll_dcnt,
    output logic [NCH-1:0]                    ll_done,
    output logic [NCH-1:0]                    ll_err,
    ll_desc_fetch_mc_if.master                dma
);
    localparam int BPB = DW / 8;
    localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(DESC_WORDS + 1);
    localparam int TW  = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [15:0]   RLEN  = 16'(DESC_WORDS * BPB - 1);
    localparam logic [AW-1:0] AMASK = ~AW'(BPB - 1);

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] g, rr, pick;
    logic          any;
    logic [AW-1:0] addr_q;
    logic [CW-1:0] dcnt;
    logic [TW-1:0] tcnt;
    logic [NCH-1:0] g_oh, done_q, err_q;
    logic          last_beat, tmo_hit;

    // Walk downwards so the lowest offset from rr wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ll_req[(int'(rr) + i) % NCH]) begin
                any  = 1'b1;
                pick = GW'((int'(rr) + i) % NCH);
            end
        end
    end

    assign g_oh      = NCH'(1) << g;
    assign last_beat = dma.dma_vald && (dcnt == CW'(DESC_WORDS - 1));
    assign tmo_hit   = (TMO > 0) && !dma.dma_vald && (tcnt == TW'(TMO - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (any) state_nx = REQ;
            REQ:  if (dma.dma_ack) state_nx = DATA;
            DATA: if (last_beat || tmo_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        dma.dma_r_req  = 1'b0;
        dma.dma_r_addr = '0;
        dma.dma_r_len  = '0;
        dma.dma_dack   = 1'b0;
        ll_ack         = '0;
        ll_dvld        = '0;
        ll_rdata       = '0;
        unique case (state)
            REQ: begin
                dma.dma_r_req  = 1'b1;
                dma.dma_r_addr = addr_q;
                dma.dma_r_len  = RLEN;
                if (dma.dma_ack) ll_ack = g_oh;
            end
            DATA: begin
                dma.dma_dack = 1'b1;
                if (dma.dma_vald) begin
                    ll_dvld  = g_oh;
                    ll_rdata = dma.dma_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            g      <= '0;
            rr     <= '0;
            addr_q <= '0;
            dcnt   <= '0;
            tcnt   <= '0;
            done_q <= '0;
            err_q  <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            unique case (state)
                IDLE: if (any) begin
                    g      <= pick;
                    addr_q <= ll_addr[int'(pick)*AW +: AW] & AMASK;
                end
                REQ: if (dma.dma_ack) begin
                    dcnt <= '0;
                    tcnt <= '0;
                    rr   <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
                end
                DATA: begin
                    if (dma.dma_vald) begin
                        dcnt <= dcnt + 1'b1;
                        tcnt <= '0;
                        if (last_beat) done_q <= g_oh;
                    end else if (tmo_hit) begin
                        err_q <= g_oh;
                    end else if (TMO > 0) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ll_dcnt = dcnt;
    assign ll_done = done_q;
    assign ll_err  = err_q;
endmodule

// File: tb/tb_ll_desc_fetch_mc.sv
// Bench for ll_desc_fetch_mc: random-driven DMA slave and requesters,
// expected events queued by a round-robin model, checked by a monitor.
module tb_ll_desc_fetch_mc;
    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NW  = 6;
    localparam int TMO = 8;

    typedef struct {
        int          ch;
        logic [31:0] v;
        int          idx;
        int          cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NCH-1:0]    ll_req;
    logic [NCH*AW-1:0] ll_addr;
    logic [NCH-1:0]    ll_ack, ll_dvld, ll_done, ll_err;
    logic [DW-1:0]     ll_rdata;
    logic [2:0]        ll_dcnt;

    exp_t ackq[$];
    exp_t beatq[$];
    exp_t endq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   model_rr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ll_desc_fetch_mc_if #(.AW(AW), .DW(DW)) dma ();

    ll_desc_fetch_mc #(
        .NCH(NCH), .AW(AW), .DW(DW), .DESC_WORDS(NW), .TMO(TMO)
    ) dut (
        .clk(clk), .rstn(rstn), .ll_req(ll_req), .ll_addr(ll_addr),
        .ll_ack(ll_ack), .ll_dvld(ll_dvld), .ll_rdata(ll_rdata),
        .ll_dcnt(ll_dcnt), .ll_done(ll_done), .ll_err(ll_err), .dma(dma)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int oh2i(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (model_rr + i) % NCH;
            if (ll_req[c]) return c;
        end
        return -1;
    endfunction

    // Monitor: every presented output event must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            if (ll_ack != 0) begin
                chk("ack_onehot", 32'($countones(ll_ack)), 1);
                if (ackq.size() == 0) chk("ack_unexpected", 32'(ll_ack), 0);
                else begin
                    e = ackq.pop_front();
                    chk("ack_ch", 32'(oh2i(ll_ack)), 32'(e.ch));
                    chk("r_addr", dma.dma_r_addr, e.v);
                    chk("r_len", 32'(dma.dma_r_len), 32'(NW * 4 - 1));
                end
            end
            if (ll_dvld != 0) begin
                chk("dvld_onehot", 32'($countones(ll_dvld)), 1);
                if (beatq.size() == 0) chk("dvld_unexpected", 32'(ll_dvld), 0);
                else begin
                    e = beatq.pop_front();
                    chk("dvld_ch", 32'(oh2i(ll_dvld)), 32'(e.ch));
                    chk("dcnt", 32'(ll_dcnt), 32'(e.idx));
                    chk("rdata", ll_rdata, e.v);
                end
            end
            if ((ll_done | ll_err) != 0) begin
                chk("end_onehot", 32'($countones({ll_done, ll_err})), 1);
                if (endq.size() == 0) chk("end_unexpected", 32'({ll_done, ll_err}), 0);
                else begin
                    e = endq.pop_front();
                    chk("end_kind_err", 32'(ll_err != 0), 32'(e.idx));
                    chk("end_ch", 32'(oh2i(ll_done | ll_err)), 32'(e.ch));
                    chk("end_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_end(input int ch, input int err, input int c);
        exp_t e;
        e.ch = ch; e.v = '0; e.idx = err; e.cyc = c;
        endq.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ll_ack), 0);
        chk({tag, "_dvld"}, 32'(ll_dvld), 0);
        chk({tag, "_done"}, 32'(ll_done), 0);
        chk({tag, "_err"}, 32'(ll_err), 0);
        chk({tag, "_rdata"}, ll_rdata, 0);
        chk({tag, "_dcnt"}, 32'(ll_dcnt), 0);
        chk({tag, "_rreq"}, 32'(dma.dma_r_req), 0);
        chk({tag, "_raddr"}, dma.dma_r_addr, 0);
        chk({tag, "_dack"}, 32'(dma.dma_dack), 0);
    endtask

    // dropmode: 0 granted channel drops, 1 all keep requesting, 2 all drop.
    task automatic run_desc(input int ack_dly, input int nbeats, input int gap,
                            input int dropmode, input int rst_at);
        int ch, n, ref_c, g;
        bit abort;
        exp_t e;
        logic [31:0] d;
        ch = model_pick();
        checks++;
        if (ch < 0) begin
            failures++;
            $display("FAIL grant_model no requester ll_req=%0h", ll_req);
            return;
        end
        e.ch = ch; e.v = ll_addr[ch*AW +: AW] & 32'hFFFF_FFFC;
        e.idx = 0; e.cyc = 0;
        ackq.push_back(e);
        n = 0;
        while (dma.dma_r_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("req_wait", 32'(n < 50), 1);
        if (n >= 50) return;
        for (int i = 0; i < ack_dly; i++) begin
            chk("req_hold", 32'(dma.dma_r_req), 1);
            chk("addr_hold", dma.dma_r_addr, e.v);
            chk("no_early_ack", 32'(ll_ack), 0);
            step();
        end
        dma.dma_ack = 1'b1;
        step();
        dma.dma_ack = 1'b0;
        ref_c = cyc - 1;
        model_rr = (ch + 1) % NCH;
        if (dropmode == 0) ll_req[ch] = 1'b0;
        if (dropmode == 2) ll_req = '0;
        abort = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            if (!abort && (cyc + g - ref_c) > TMO) begin
                abort = 1'b1;
                push_end(ch, 1, ref_c + TMO + 1);
            end
            for (int j = 0; j < g; j++) step();
            if (k == rst_at) begin
                dma.dma_vald = 1'b1;
                dma.dma_data = $urandom;
                rstn = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                step();
                dma.dma_vald = 1'b0;
                ll_req = '0;
                step();
                rstn = 1'b1;
                model_rr = 0;
                return;
            end
            d = $urandom;
            dma.dma_vald = 1'b1;
            dma.dma_data = d;
            if (!abort && k < NW) begin
                e.ch = ch; e.v = d; e.idx = k; e.cyc = cyc;
                beatq.push_back(e);
                ref_c = cyc;
                if (k == NW - 1) push_end(ch, 0, cyc + 1);
            end
            step();
            dma.dma_vald = 1'b0;
        end
        if (!abort && nbeats < NW) begin
            push_end(ch, 1, ref_c + TMO + 1);
            repeat (TMO + 2) step();
        end else begin
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        ll_req = '0;
        ll_addr = '0;
        dma.dma_ack = 1'b0;
        dma.dma_vald = 1'b0;
        dma.dma_data = '0;
        #2;
        chk_all_zero("reset");
        repeat (3) step();
        rstn = 1'b1;
        step();

        // All channels held: grants 0,1,2,3,0.
        for (int c = 0; c < NCH; c++) ll_addr[c*AW +: AW] = $urandom;
        ll_req = 4'b1111;
        for (int i = 0; i < 5; i++)
            run_desc(int'($urandom_range(0, 2)), NW, -1, (i == 4) ? 2 : 1, -1);
        chk("rr_after_wrap", 32'(model_rr), 1);

        // Unaligned address, back-to-back beats, count holds after done.
        ll_addr[0 +: AW] = 32'h1003;
        ll_req = 4'b0001;
        run_desc(0, NW, 0, 0, -1);
        chk("dcnt_hold", 32'(ll_dcnt), NW);

        // Slow DMA accept on channel 2.
        ll_req = 4'b0100;
        run_desc(10, NW, 0, 0, -1);

        // Three beats then silence; stray beats afterwards are dropped.
        ll_req = 4'b0010;
        run_desc(0, 3, 0, 0, -1);
        chk("dack_idle", 32'(dma.dma_dack), 0);
        for (int i = 0; i < 2; i++) begin
            dma.dma_vald = 1'b1;
            dma.dma_data = $urandom;
            step();
            dma.dma_vald = 1'b0;
            step();
        end

        // One beat every third cycle.
        ll_req = 4'b1000;
        run_desc(1, NW, 2, 0, -1);

        // Random request mixes and beat gaps.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NCH; c++) ll_addr[c*AW +: AW] = $urandom;
            ll_req = 4'($urandom_range(1, 15));
            while (ll_req != 0)
                run_desc(int'($urandom_range(0, 3)), NW, -1, 0, -1);
        end

        // Long mid-descriptor gap aborts it.
        ll_req = 4'b0001;
        run_desc(0, NW, TMO + 1, 0, -1);
        repeat (3) step();

        // Reset during beat 3, then rr restarts at 0.
        ll_req = 4'b0100;
        run_desc(0, NW, 0, 0, 3);
        chk("rst_ackq", 32'(ackq.size()), 0);
        chk("rst_beatq", 32'(beatq.size()), 0);
        ll_req = 4'b1010;
        run_desc(0, NW, 0, 0, -1);
        ll_req = '0;

        repeat (5) step();
        chk("left_ack", 32'(ackq.size()), 0);
        chk("left_beat", 32'(beatq.size()), 0);
        chk("left_end", 32'(endq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
